// File: rtl/systolic_share_arbiter.sv
// Round-robin time-share arbiter placing one linear-layer controller at a time on the shared
// systolic array. The grant is held for a full output tile, until the owner pulses release.
module systolic_share_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned UNIT_NUM   = 16,
    parameter int unsigned PSUM_WIDTH = 80
) (
    input  logic                            s_clk,
    input  logic                            s_rst,

    // Requester side
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ-1:0]              i_release,
    output logic [NUM_REQ-1:0]              o_gnt,
    input  logic [NUM_REQ-1:0]              i_Init_PrepareData,
    input  logic [NUM_REQ-1:0]              i_MtrxA_valid,
    input  logic [NUM_REQ-1:0]              i_MtrxA_done,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_MtrxA_data,
    input  logic [NUM_REQ-1:0]              i_MtrxB_valid,
    input  logic [NUM_REQ-1:0]              i_MtrxB_done,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_MtrxB_data,
    input  logic [NUM_REQ*UNIT_NUM-1:0]     i_PsumFIFO_Grant,
    input  logic [NUM_REQ-1:0]              i_PsumFIFO_Valid,
    output logic [NUM_REQ-1:0]              o_MtrxA_ready,
    output logic [NUM_REQ-1:0]              o_MtrxB_ready,
    output logic [NUM_REQ-1:0]              o_Finish_Calc,
    output logic [PSUM_WIDTH-1:0]           o_PsumFIFO_Data,

    // Array side
    output logic                            o_Init_PrepareData,
    output logic                            MtrxA_slice_valid,
    output logic                            MtrxA_slice_done,
    output logic [DATA_WIDTH-1:0]           MtrxA_slice_data,
    output logic                            MtrxB_slice_valid,
    output logic                            MtrxB_slice_done,
    output logic [DATA_WIDTH-1:0]           MtrxB_slice_data,
    output logic [UNIT_NUM-1:0]             o_PsumFIFO_Grant,
    output logic                            o_PsumFIFO_Valid,
    input  logic                            MtrxA_slice_ready,
    input  logic                            MtrxB_slice_ready,
    input  logic                            i_Finish_Calc,
    input  logic [PSUM_WIDTH-1:0]           i_PsumFIFO_Data,

    // Status
    output logic                            o_busy,
    output logic [NUM_REQ*16-1:0]           o_tile_cnt
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_BUSY    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [PTR_W-1:0]      r_ptr_q, r_ptr_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ*16-1:0] tile_cnt_q, tile_cnt_d;

    logic [PTR_W-1:0]      win_idx;
    logic                  win_found;
    int                    cand;
    logic [NUM_REQ-1:0]    owner_oh;
    logic                  mux_live;

    // Winner is the first requester at or after r_ptr, searching with wrap-around.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = int'(r_ptr_q) + k;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            if (!win_found && i_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        r_ptr_d    = r_ptr_q;
        gnt_d      = gnt_q;
        tile_cnt_d = tile_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    owner_d = win_idx;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                end
            end
            S_GRANT: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // Releases from anyone but the owner are dropped here.
                if (i_release[owner_q]) begin
                    state_d = S_RELEASE;
                    gnt_d   = '0;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                r_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);
                tile_cnt_d[owner_q*16 +: 16] = tile_cnt_q[owner_q*16 +: 16] + 16'd1;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            r_ptr_q    <= '0;
            gnt_q      <= '0;
            tile_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            r_ptr_q    <= r_ptr_d;
            gnt_q      <= gnt_d;
            tile_cnt_q <= tile_cnt_d;
        end
    end

    // The array path is only live in S_BUSY; the guard states and reset force it to zero.
    assign mux_live = (state_q == S_BUSY);
    assign owner_oh = NUM_REQ'(1) << owner_q;

    always_comb begin
        o_Init_PrepareData = 1'b0;
        MtrxA_slice_valid  = 1'b0;
        MtrxA_slice_done   = 1'b0;
        MtrxA_slice_data   = '0;
        MtrxB_slice_valid  = 1'b0;
        MtrxB_slice_done   = 1'b0;
        MtrxB_slice_data   = '0;
        o_PsumFIFO_Grant   = '0;
        o_PsumFIFO_Valid   = 1'b0;
        o_MtrxA_ready      = '0;
        o_MtrxB_ready      = '0;
        o_Finish_Calc      = '0;
        if (mux_live) begin
            o_Init_PrepareData = i_Init_PrepareData[owner_q];
            MtrxA_slice_valid  = i_MtrxA_valid[owner_q];
            MtrxA_slice_done   = i_MtrxA_done[owner_q];
            MtrxA_slice_data   = i_MtrxA_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
            MtrxB_slice_valid  = i_MtrxB_valid[owner_q];
            MtrxB_slice_done   = i_MtrxB_done[owner_q];
            MtrxB_slice_data   = i_MtrxB_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
            o_PsumFIFO_Grant   = i_PsumFIFO_Grant[owner_q*UNIT_NUM +: UNIT_NUM];
            o_PsumFIFO_Valid   = i_PsumFIFO_Valid[owner_q];
            o_MtrxA_ready      = MtrxA_slice_ready ? owner_oh : '0;
            o_MtrxB_ready      = MtrxB_slice_ready ? owner_oh : '0;
            o_Finish_Calc      = i_Finish_Calc ? owner_oh : '0;
        end
    end

    assign o_PsumFIFO_Data = i_PsumFIFO_Data;
    assign o_gnt           = gnt_q;
    assign o_busy          = (state_q != S_IDLE);
    assign o_tile_cnt      = tile_cnt_q;

    a_gnt_onehot0 : assert property (@(posedge s_clk) disable iff (!s_rst) $onehot0(gnt_q));
    a_gnt_in_busy : assert property (@(posedge s_clk) disable iff (!s_rst)
                                     (state_q == S_BUSY) |-> (gnt_q == owner_oh));

endmodule

// File: tb/tb_systolic_share_arbiter.sv
// Directed bench for systolic_share_arbiter: contention order, mux isolation, spurious release,
// pointer wrap and asynchronous reset mid-tile.
module tb_systolic_share_arbiter;

    localparam int NR = 3;
    localparam int DW = 64;
    localparam int UN = 16;
    localparam int PW = 80;

    logic              s_clk = 1'b0;
    logic              s_rst;
    logic [NR-1:0]     i_req, i_release, o_gnt;
    logic [NR-1:0]     i_Init_PrepareData, i_MtrxA_valid, i_MtrxA_done;
    logic [NR-1:0]     i_MtrxB_valid, i_MtrxB_done, i_PsumFIFO_Valid;
    logic [NR*DW-1:0]  i_MtrxA_data, i_MtrxB_data;
    logic [NR*UN-1:0]  i_PsumFIFO_Grant;
    logic [NR-1:0]     o_MtrxA_ready, o_MtrxB_ready, o_Finish_Calc;
    logic [PW-1:0]     o_PsumFIFO_Data, i_PsumFIFO_Data;
    logic              o_Init_PrepareData, MtrxA_slice_valid, MtrxA_slice_done;
    logic              MtrxB_slice_valid, MtrxB_slice_done, o_PsumFIFO_Valid;
    logic [DW-1:0]     MtrxA_slice_data, MtrxB_slice_data;
    logic [UN-1:0]     o_PsumFIFO_Grant;
    logic              MtrxA_slice_ready, MtrxB_slice_ready, i_Finish_Calc;
    logic              o_busy;
    logic [NR*16-1:0]  o_tile_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 s_clk = ~s_clk;

    systolic_share_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .UNIT_NUM(UN), .PSUM_WIDTH(PW)
    ) dut (
        .s_clk(s_clk), .s_rst(s_rst),
        .i_req(i_req), .i_release(i_release), .o_gnt(o_gnt),
        .i_Init_PrepareData(i_Init_PrepareData),
        .i_MtrxA_valid(i_MtrxA_valid), .i_MtrxA_done(i_MtrxA_done), .i_MtrxA_data(i_MtrxA_data),
        .i_MtrxB_valid(i_MtrxB_valid), .i_MtrxB_done(i_MtrxB_done), .i_MtrxB_data(i_MtrxB_data),
        .i_PsumFIFO_Grant(i_PsumFIFO_Grant), .i_PsumFIFO_Valid(i_PsumFIFO_Valid),
        .o_MtrxA_ready(o_MtrxA_ready), .o_MtrxB_ready(o_MtrxB_ready),
        .o_Finish_Calc(o_Finish_Calc), .o_PsumFIFO_Data(o_PsumFIFO_Data),
        .o_Init_PrepareData(o_Init_PrepareData),
        .MtrxA_slice_valid(MtrxA_slice_valid), .MtrxA_slice_done(MtrxA_slice_done),
        .MtrxA_slice_data(MtrxA_slice_data),
        .MtrxB_slice_valid(MtrxB_slice_valid), .MtrxB_slice_done(MtrxB_slice_done),
        .MtrxB_slice_data(MtrxB_slice_data),
        .o_PsumFIFO_Grant(o_PsumFIFO_Grant), .o_PsumFIFO_Valid(o_PsumFIFO_Valid),
        .MtrxA_slice_ready(MtrxA_slice_ready), .MtrxB_slice_ready(MtrxB_slice_ready),
        .i_Finish_Calc(i_Finish_Calc), .i_PsumFIFO_Data(i_PsumFIFO_Data),
        .o_busy(o_busy), .o_tile_cnt(o_tile_cnt)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    // Starts in S_IDLE with the request already applied; ends back in S_IDLE.
    task automatic do_tile(input int owner);
        tick();
        check("tile_grant", 80'(o_gnt), 80'(1 << owner));
        check("tile_busy", 80'(o_busy), 80'(1));
        tick();
        i_release = NR'(1 << owner);
        tick();
        i_release = '0;
        check("tile_gnt_drop", 80'(o_gnt), 80'(0));
        tick();
        check("tile_idle", 80'(o_busy), 80'(0));
    endtask

    initial begin
        s_rst = 1'b0;
        i_req = '0; i_release = '0; i_Init_PrepareData = '0;
        i_MtrxA_valid = '0; i_MtrxA_done = '0; i_MtrxA_data = '0;
        i_MtrxB_valid = '0; i_MtrxB_done = '0; i_MtrxB_data = '0;
        i_PsumFIFO_Grant = '0; i_PsumFIFO_Valid = '0;
        MtrxA_slice_ready = 1'b0; MtrxB_slice_ready = 1'b0; i_Finish_Calc = 1'b0;
        i_PsumFIFO_Data = 80'h1234_5678_9ABC_DEF0_1357;
        #12;
        check("rst_gnt", 80'(o_gnt), 80'(0));
        check("rst_busy", 80'(o_busy), 80'(0));
        check("rst_cnt", 80'(o_tile_cnt), 80'(0));
        check("psum_passthru_rst", 80'(o_PsumFIFO_Data), 80'h1234_5678_9ABC_DEF0_1357);
        s_rst = 1'b1;
        tick();

        // Contention: all three held for six tiles.
        i_req = 3'b111;
        do_tile(0); do_tile(1); do_tile(2);
        do_tile(0); do_tile(1); do_tile(2);
        i_req = '0;
        check("contention_cnt", 80'(o_tile_cnt), 80'({16'd2, 16'd2, 16'd2}));

        // Single requester 0 with a 32-beat MtrxB burst.
        i_req = 3'b001;
        i_MtrxB_valid = 3'b001;
        i_MtrxB_data[63:0] = 64'hAAAA_0000_0000_0001;
        tick();
        check("single_gnt", 80'(o_gnt), 80'(3'b001));
        check("guard_forced", 80'(MtrxB_slice_valid), 80'(0));
        tick();
        MtrxB_slice_ready = 1'b1;
        for (int b = 0; b < 32; b++) begin
            i_MtrxB_data[63:0] = 64'hB000_0000_0000_0000 + 64'(b * 7 + 3);
            #1;
            check("burst_data", 80'(MtrxB_slice_data), 80'(64'hB000_0000_0000_0000 + 64'(b * 7 + 3)));
            if (b == 5) begin
                check("burst_valid", 80'(MtrxB_slice_valid), 80'(1));
                check("burst_ready", 80'(o_MtrxB_ready), 80'(3'b001));
            end
            tick();
        end
        i_req = '0;
        i_release = 3'b001;
        tick();
        i_release = '0;
        check("single_rel_gnt", 80'(o_gnt), 80'(0));
        check("rel_forced", 80'(MtrxB_slice_valid), 80'(0));
        check("rel_ready_forced", 80'(o_MtrxB_ready), 80'(0));
        tick();
        i_MtrxB_valid = '0; MtrxB_slice_ready = 1'b0;
        check("single_cnt0", 80'(o_tile_cnt[15:0]), 80'(3));

        // Isolation: owner 1 while requester 0 drives garbage.
        i_req = 3'b010;
        tick();
        check("iso_gnt", 80'(o_gnt), 80'(3'b010));
        tick();
        i_MtrxA_valid = 3'b001;
        i_MtrxA_data = {64'h0, 64'h1111_2222_3333_4444, 64'hDEAD};
        i_Init_PrepareData = 3'b001;
        i_PsumFIFO_Grant = {16'h0, 16'h00F0, 16'hFFFF};
        i_PsumFIFO_Valid = 3'b001;
        MtrxA_slice_ready = 1'b1;
        i_Finish_Calc = 1'b1;
        #1;
        check("iso_valid", 80'(MtrxA_slice_valid), 80'(0));
        check("iso_data", 80'(MtrxA_slice_data), 80'(64'h1111_2222_3333_4444));
        check("iso_init", 80'(o_Init_PrepareData), 80'(0));
        check("iso_pgrant", 80'(o_PsumFIFO_Grant), 80'(16'h00F0));
        check("iso_pvalid", 80'(o_PsumFIFO_Valid), 80'(0));
        check("iso_ready", 80'(o_MtrxA_ready), 80'(3'b010));
        check("iso_finish", 80'(o_Finish_Calc), 80'(3'b010));
        i_MtrxA_valid = 3'b011;
        #1;
        check("iso_valid_own", 80'(MtrxA_slice_valid), 80'(1));
        check("iso_data_own", 80'(MtrxA_slice_data), 80'(64'h1111_2222_3333_4444));
        i_req = '0;
        i_release = 3'b010;
        tick();
        i_release = '0;
        check("iso_fin_forced", 80'(o_Finish_Calc), 80'(0));
        tick();
        i_MtrxA_valid = '0; i_MtrxA_data = '0; i_Init_PrepareData = '0;
        i_PsumFIFO_Grant = '0; i_PsumFIFO_Valid = '0;
        MtrxA_slice_ready = 1'b0; i_Finish_Calc = 1'b0;

        // Pointer wrap: pointer at 2, requests 0 and 2.
        i_req = 3'b101;
        do_tile(2);
        tick();
        check("wrap_gnt", 80'(o_gnt), 80'(3'b001));
        tick();
        // Spurious release from 2 and dropped request from 0 must not disturb the grant.
        i_release = 3'b100;
        i_req = 3'b100;
        tick();
        i_release = '0;
        check("spur_gnt", 80'(o_gnt), 80'(3'b001));
        check("spur_busy", 80'(o_busy), 80'(1));
        tick();
        check("drop_req_gnt", 80'(o_gnt), 80'(3'b001));
        i_req = '0;
        i_release = 3'b001;
        tick();
        i_release = '0;
        tick();
        check("wrap_cnt", 80'(o_tile_cnt), 80'({16'd3, 16'd3, 16'd4}));

        // Async reset in the middle of a MtrxB burst.
        i_req = 3'b001;
        tick();
        tick();
        i_MtrxB_valid = 3'b001;
        i_MtrxB_data[63:0] = 64'hCAFE_F00D;
        MtrxB_slice_ready = 1'b1;
        #1;
        check("pre_rst_valid", 80'(MtrxB_slice_valid), 80'(1));
        #1;
        s_rst = 1'b0;
        #1;
        check("arst_gnt", 80'(o_gnt), 80'(0));
        check("arst_busy", 80'(o_busy), 80'(0));
        check("arst_valid", 80'(MtrxB_slice_valid), 80'(0));
        check("arst_data", 80'(MtrxB_slice_data), 80'(0));
        check("arst_ready", 80'(o_MtrxB_ready), 80'(0));
        check("arst_cnt", 80'(o_tile_cnt), 80'(0));
        i_MtrxB_valid = '0; MtrxB_slice_ready = 1'b0;
        i_req = 3'b110;
        #2;
        s_rst = 1'b1;
        tick();
        check("post_rst_gnt", 80'(o_gnt), 80'(3'b010));
        i_req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
